// File: rtl/axis_pkt_pkg.sv
// Shared definitions for the AXI-stream line packetizer: FSM encoding and
// status counter width.
package axis_pkt_pkg;

    localparam logic [0:0] WAIT_SYNC = 1'b0;
    localparam logic [0:0] ACTIVE    = 1'b1;

    localparam int STATUS_CNT_W = 16;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry skid buffer (output register + skid register). Upstream ready is a
// flop output, so there is no combinational path from out_ready to in_ready.
module axis_skid_reg #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             vld_p1;
    logic             skid_valid_reg;
    logic [WIDTH-1:0] data_p1;
    logic [WIDTH-1:0] skid_data;
    logic             load_out;

    assign load_out  = !vld_p1 || out_ready;
    assign in_ready  = !skid_valid_reg;
    assign out_valid = vld_p1;
    assign out_data  = data_p1;

    // stage p1: output register, skid register catches the beat during a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1         <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            if (out_ready) begin
                vld_p1         <= 1'b1;
                skid_valid_reg <= 1'b0;
            end
        end else if (load_out) begin
            vld_p1 <= in_valid;
        end else if (in_valid) begin
            skid_valid_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (skid_valid_reg) begin
            if (out_ready) begin
                data_p1 <= skid_data;
            end
        end else if (load_out) begin
            if (in_valid) begin
                data_p1 <= in_data;
            end
        end else if (in_valid) begin
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/axis_line_packetizer.sv
// Frames an unframed pixel stream into AXI-stream lines (tlast) and frames
// (tuser). Status outputs exist only when AXIS_LINE_PKT_STATUS_EN is defined.
module axis_line_packetizer
    import axis_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_sync,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    status_frame_done,
    output logic                    status_short_frame,
    output logic [STATUS_CNT_W-1:0] status_drop_cnt
);

    localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(H_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(V_ACTIVE - 1);

    logic [0:0]            state;
    logic [CNT_WIDTH-1:0]  x;
    logic [CNT_WIDTH-1:0]  y;
    logic [CNT_WIDTH-1:0]  cur_x;
    logic [CNT_WIDTH-1:0]  cur_y;
    logic [CNT_WIDTH-1:0]  nx;
    logic [CNT_WIDTH-1:0]  ny;
    logic                  accept;
    logic                  fwd;
    logic                  pix_first;
    logic                  pix_last;
    logic                  eof;
    logic [DATA_WIDTH+1:0] out_payload;
    logic                  out_valid;

    // frame_sync overrides the counters for the beat arriving in the same cycle
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign fwd       = accept && (frame_sync || state == ACTIVE);
    assign cur_x     = frame_sync ? '0 : x;
    assign cur_y     = frame_sync ? '0 : y;
    assign pix_first = (cur_x == '0) && (cur_y == '0);
    assign pix_last  = (cur_x == X_LAST);
    assign eof       = pix_last && (cur_y == Y_LAST);
    assign nx        = pix_last ? '0 : cur_x + 1'b1;
    assign ny        = pix_last ? ((cur_y < Y_LAST) ? cur_y + 1'b1 : '0) : cur_y;

    // stage p0: position tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_SYNC;
            x     <= '0;
            y     <= '0;
        end else if (fwd) begin
            x     <= nx;
            y     <= ny;
            state <= eof ? WAIT_SYNC : ACTIVE;
        end else if (frame_sync) begin
            x     <= '0;
            y     <= '0;
            state <= ACTIVE;
        end
    end

    axis_skid_reg #(
        .WIDTH (DATA_WIDTH + 2)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({pix_last, pix_first, s_axis_tdata}),
        .in_valid  (fwd),
        .in_ready  (s_axis_tready),
        .out_data  (out_payload),
        .out_valid (out_valid),
        .out_ready (m_axis_tready)
    );

    // payload flops carry no reset, so sideband flags are qualified by valid
    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_payload[DATA_WIDTH-1:0];
    assign m_axis_tuser  = out_valid && out_payload[DATA_WIDTH];
    assign m_axis_tlast  = out_valid && out_payload[DATA_WIDTH+1];

`ifdef AXIS_LINE_PKT_STATUS_EN
    logic                    frame_done_p1;
    logic                    short_frame_p1;
    logic [STATUS_CNT_W-1:0] drop_cnt;

    function automatic logic [STATUS_CNT_W-1:0] sat_inc(input logic [STATUS_CNT_W-1:0] v);
        return (v == {STATUS_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // stage p1: status pulses and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_p1  <= 1'b0;
            short_frame_p1 <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            frame_done_p1  <= fwd && eof;
            short_frame_p1 <= frame_sync && (state == ACTIVE) && ((x != '0) || (y != '0));
            if (accept && (state == WAIT_SYNC) && !frame_sync) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    assign status_frame_done  = frame_done_p1;
    assign status_short_frame = short_frame_p1;
    assign status_drop_cnt    = drop_cnt;
`else
    assign status_frame_done  = 1'b0;
    assign status_short_frame = 1'b0;
    assign status_drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_axis_line_packetizer.sv
// Directed bench for axis_line_packetizer with a 4x2 frame.
module tb_axis_line_packetizer;

`ifdef AXIS_LINE_PKT_STATUS_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_sync;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        status_frame_done;
    logic        status_short_frame;
    logic [15:0] status_drop_cnt;

    int checks   = 0;
    int failures = 0;

    axis_line_packetizer #(
        .DATA_WIDTH (32),
        .H_ACTIVE   (4),
        .V_ACTIVE   (2),
        .CNT_WIDTH  (12)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .frame_sync         (frame_sync),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tuser       (m_axis_tuser),
        .status_frame_done  (status_frame_done),
        .status_short_frame (status_short_frame),
        .status_drop_cnt    (status_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic vld, input logic [31:0] d, input logic rdy);
        frame_sync    = fs;
        s_axis_tvalid = vld;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic u, input logic l);
        chk({tag, "_vld"}, 64'(m_axis_tvalid), 64'(1'b1));
        chk({tag, "_data"}, 64'(m_axis_tdata), 64'(d));
        chk({tag, "_user"}, 64'(m_axis_tuser), 64'(u));
        chk({tag, "_last"}, 64'(m_axis_tlast), 64'(l));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        frame_sync    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        do_reset();

        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
        chk("rst_tlast", 64'(m_axis_tlast), 64'(1'b0));
        chk("rst_tuser", 64'(m_axis_tuser), 64'(1'b0));
        chk("rst_sready", 64'(s_axis_tready), 64'(1'b1));
        chk("rst_done", 64'(status_frame_done), 64'(1'b0));
        chk("rst_short", 64'(status_short_frame), 64'(1'b0));
        chk("rst_drop", 64'(status_drop_cnt), 64'(16'd0));

        // full frame, back-to-back
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 1'b1, 32'(i), 1'b1);
            chk_out("frm", 32'(i), i == 0, (i == 3) || (i == 7));
            chk("frm_done", 64'(status_frame_done), 64'(ST && (i == 7)));
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("frm_idle_vld", 64'(m_axis_tvalid), 64'(1'b0));
        chk("frm_done_once", 64'(status_frame_done), 64'(1'b0));

        // beats before frame_sync are dropped
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h100 + 32'(i), 1'b1);
            chk("drop_vld", 64'(m_axis_tvalid), 64'(1'b0));
        end
        drive(1'b1, 1'b1, 32'hA, 1'b1);
        chk_out("sync_a", 32'hA, 1'b1, 1'b0);
        chk("drop_cnt", 64'(status_drop_cnt), ST ? 64'd3 : 64'd0);

        // short frame
        do_reset();
        drive(1'b1, 1'b1, 32'h10, 1'b1);
        chk_out("sf0", 32'h10, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h11, 1'b1);
        drive(1'b0, 1'b1, 32'h12, 1'b1);
        drive(1'b0, 1'b1, 32'h13, 1'b1);
        chk_out("sf3", 32'h13, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'h14, 1'b1);
        chk_out("sf4", 32'h14, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h20, 1'b1);
        chk_out("sf_resync", 32'h20, 1'b1, 1'b0);
        chk("sf_short", 64'(status_short_frame), 64'(ST));
        chk("sf_nodone", 64'(status_frame_done), 64'(1'b0));
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sf_short_end", 64'(status_short_frame), 64'(1'b0));

        // backpressure through the skid register
        do_reset();
        drive(1'b1, 1'b1, 32'h30, 1'b1);
        chk_out("bp0", 32'h30, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h31, 1'b1);
        chk_out("bp1", 32'h31, 1'b0, 1'b0);
        chk("bp1_sready", 64'(s_axis_tready), 64'(1'b1));
        drive(1'b0, 1'b1, 32'h32, 1'b0);
        chk_out("bp2", 32'h31, 1'b0, 1'b0);
        chk("bp2_sready", 64'(s_axis_tready), 64'(1'b0));
        drive(1'b0, 1'b1, 32'h33, 1'b0);
        chk_out("bp3", 32'h31, 1'b0, 1'b0);
        chk("bp3_sready", 64'(s_axis_tready), 64'(1'b0));
        drive(1'b0, 1'b1, 32'h33, 1'b1);
        chk_out("bp4", 32'h32, 1'b0, 1'b0);
        chk("bp4_sready", 64'(s_axis_tready), 64'(1'b1));
        drive(1'b0, 1'b1, 32'h33, 1'b1);
        chk_out("bp5", 32'h33, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp_idle_vld", 64'(m_axis_tvalid), 64'(1'b0));

        // asynchronous reset with the skid register full
        do_reset();
        drive(1'b1, 1'b1, 32'h40, 1'b0);
        drive(1'b0, 1'b1, 32'h41, 1'b0);
        chk("ar_full_sready", 64'(s_axis_tready), 64'(1'b0));
        chk_out("ar_hold", 32'h40, 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        frame_sync    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
        chk("ar_tuser", 64'(m_axis_tuser), 64'(1'b0));
        chk("ar_sready", 64'(s_axis_tready), 64'(1'b1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 32'h42, 1'b1);
        chk("ar_drop0", 64'(m_axis_tvalid), 64'(1'b0));
        drive(1'b0, 1'b1, 32'h43, 1'b1);
        chk("ar_drop1", 64'(m_axis_tvalid), 64'(1'b0));
        chk("ar_drop_cnt", 64'(status_drop_cnt), ST ? 64'd2 : 64'd0);
        drive(1'b1, 1'b1, 32'h50, 1'b1);
        chk_out("ar_sync", 32'h50, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_line_packetizer.md
AXIS_LINE_PACKETIZER -- requirements
Module: axis_line_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel beat width.
REQ-002 SHALL have parameter H_ACTIVE, default 640, beats per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-004 SHALL have parameter CNT_WIDTH, default 12, width of x/y counters; must satisfy 2**CNT_WIDTH >= max(H_ACTIVE, V_ACTIVE).
REQ-005 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port frame_sync  input  1  single-cycle start-of-frame pulse from the sensor/DMA side.
REQ-008 SHALL have ports s_axis_tdata  input  DATA_WIDTH; s_axis_tvalid  input  1; s_axis_tready  output  1. Unframed pixel input, no tlast/tuser.
REQ-009 SHALL have ports m_axis_tdata  output  DATA_WIDTH; m_axis_tvalid  output  1; m_axis_tready  input  1; m_axis_tlast  output  1 (end of line); m_axis_tuser  output  1 (start of frame). Feeds the AXI-stream FIFO.
REQ-010 SHALL have ports status_frame_done  output  1; status_short_frame  output  1; status_drop_cnt  output  16.

Function
REQ-011 SHALL implement a two-state FSM: WAIT_SYNC (reset state) and ACTIVE.
REQ-012 A beat is accepted when s_axis_tvalid && s_axis_tready. s_axis_tready SHALL equal !skid_valid_reg, registered, with no combinational path from m_axis_tready.
REQ-013 In WAIT_SYNC without frame_sync, accepted beats SHALL be discarded, and status_drop_cnt SHALL increment by 1 per discarded beat, saturating at 16'hFFFF.
REQ-014 When frame_sync=1 in either state, x and y SHALL be 0 and the FSM SHALL be ACTIVE for that cycle's beat. A beat accepted in the same cycle SHALL be forwarded as pixel (0,0) with tuser=1.
REQ-015 In ACTIVE, every accepted beat SHALL be forwarded. tuser=1 iff x==0 && y==0. tlast=1 iff x==H_ACTIVE-1.
REQ-016 Counter update per forwarded beat: x<H_ACTIVE-1 gives x+1. Otherwise x goes to 0, and y goes to y+1 if y<V_ACTIVE-1.
REQ-017 On the beat with x==H_ACTIVE-1 && y==V_ACTIVE-1: the FSM SHALL go to WAIT_SYNC, and status_frame_done SHALL pulse high for one cycle in the following cycle.
REQ-018 frame_sync while ACTIVE and (x,y)!=(0,0) SHALL pulse status_short_frame for one cycle next cycle. Counters restart per REQ-014 and no frame_done is issued.
REQ-019 The output path SHALL be a 2-entry skid buffer (output reg + skid reg). Latency is exactly 1 cycle from acceptance to m_axis_tvalid. Throughput is 1 beat/cycle while m_axis_tready=1.
REQ-020 With m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tlast/tuser SHALL hold stable. Beats SHALL never be lost or reordered.
REQ-021 The skid reg SHALL fill only when the output reg is valid, m_axis_tready=0 and a beat is accepted. It drains to the output reg on the next cycle with m_axis_tready=1.

Reset
REQ-022 rst_n low SHALL asynchronously force: FSM=WAIT_SYNC; x=y=0; both buffer valids=0; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0; s_axis_tready=1 after release; all status outputs 0. m_axis_tdata is don't-care.
REQ-023 Reset mid-frame SHALL discard buffered beats. The first frame after release requires a fresh frame_sync.

Configuration
REQ-024 Macro AXIS_LINE_PKT_STATUS_EN defined: status_frame_done, status_short_frame and status_drop_cnt behave per REQ-013/017/018.
REQ-025 Macro AXIS_LINE_PKT_STATUS_EN undefined: the three status ports SHALL be tied to 0 and the drop counter and pulse flops SHALL not be instantiated. Streaming behaviour is identical.

Structure
REQ-026 Package axis_pkt_pkg SHALL hold the FSM state encoding (WAIT_SYNC=1'b0, ACTIVE=1'b1) and the status counter width constant (16).
REQ-027 The skid buffer SHALL be sub-module axis_skid_reg, parameterised on payload width (DATA_WIDTH+2), with async active-low reset.

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-028 Stimulus: frame_sync with 8 back-to-back beats 0..7 and m_axis_tready=1. Required: output beats 0..7 each 1 cycle later; tuser on beat 0; tlast on beats 3 and 7; frame_done pulse once.
REQ-029 Stimulus: 3 beats with no frame_sync, then frame_sync with beat 0xA. Required: drop_cnt=3; first output is 0xA with tuser=1.
REQ-030 Stimulus: frame_sync, 5 beats, then frame_sync with beat 0x20. Required: short_frame pulse; 0x20 output with tuser=1, tlast=0; no frame_done.
REQ-031 Stimulus: m_axis_tready toggles 1,0,0,1 against a continuous input stream. Required: s_axis_tready drops 1 cycle after the first stall; output data stable while stalled; no beat lost or duplicated.
REQ-032 Stimulus: rst_n asserted while the skid buffer is full. Required: m_axis_tvalid=0 immediately (asynchronous); beats arriving after release are dropped until frame_sync.
